order_match_engine: RTL

Aggressor-side matching stage sitting directly upstream of the two `heap_manager` instances (bid heap = max-heap, ask heap = min-heap). It accepts one incoming limit order at a time and matches it against the opposite book's root (`root_out`), emitting trade reports. It sequences `CMD_UPDATE`/`CMD_POP` on the opposite heap for each fill, and `CMD_PUSH` of any residual onto the own-side heap.

---
 rtl/order_match_engine_pkg.sv | 33 +++
 rtl/order_match_engine.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/order_match_engine_pkg.sv
// Shared command/state encodings and order-word helpers for the matching stage.
package order_match_engine_pkg;

  typedef enum logic [1:0] {
    CMD_NOP    = 2'd0,
    CMD_PUSH   = 2'd1,
    CMD_POP    = 2'd2,
    CMD_UPDATE = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_EVAL     = 2'd1,
    S_OPP_WAIT = 2'd2,
    S_OWN_WAIT = 2'd3
  } state_e;

  localparam logic SIDE_BID = 1'b1;
  localparam logic SIDE_ASK = 1'b0;

  function automatic logic [15:0] price_of(input logic [31:0] w);
    return w[31:16];
  endfunction

  function automatic logic [15:0] qty_of(input logic [31:0] w);
    return w[15:0];
  endfunction

  function automatic logic [31:0] mk_order(input logic [15:0] p, input logic [15:0] q);
    return {p, q};
  endfunction

endpackage

// File: rtl/order_match_engine.sv
// Aggressor matcher: fills one order against the opposite heap root, then pushes the residual.
// cmd/trade/drop registered 2 cycles after accept; in_ready low while an order is in flight, trade/drop unthrottled.
module order_match_engine
  import order_match_engine_pkg::*;
#(
  parameter int WDOG_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_side,
  input  logic [31:0] in_order,
  output logic [1:0]  bid_cmd,
  output logic [1:0]  ask_cmd,
  output logic [31:0] bid_data,
  output logic [31:0] ask_data,
  input  logic [31:0] bid_root,
  input  logic [31:0] ask_root,
  input  logic        bid_full,
  input  logic        bid_empty,
  input  logic        bid_done,
  input  logic        ask_full,
  input  logic        ask_empty,
  input  logic        ask_done,
  output logic        trade_valid,
  output logic [15:0] trade_price,
  output logic [15:0] trade_qty,
  output logic        trade_side,
  output logic        drop_valid,
  output logic        err_timeout,
  output logic [31:0] trade_count
);

  state_e      state, state_nxt;
  logic        side;
  logic [15:0] price, rem, rem_nxt;
  logic [31:0] wdog;

  logic [31:0] opp_root;
  logic [15:0] root_price, root_qty, fill_qty;
  logic        opp_empty, opp_done, own_full, own_done, crosses, waiting, timeout;

  cmd_e        cmd_val;
  logic [31:0] cmd_data;
  logic        cmd_to_bid, fire_trade, fire_drop;

  assign in_ready = (state == S_IDLE);

  always_comb begin
    opp_root   = side ? ask_root  : bid_root;
    opp_empty  = side ? ask_empty : bid_empty;
    opp_done   = side ? ask_done  : bid_done;
    own_full   = side ? bid_full  : ask_full;
    own_done   = side ? bid_done  : ask_done;
    root_price = price_of(opp_root);
    root_qty   = qty_of(opp_root);
    fill_qty   = (root_qty < rem) ? root_qty : rem;
    // equal prices cross from either side
    crosses    = !opp_empty && (side ? (price >= root_price) : (price <= root_price));
    waiting    = (state == S_OPP_WAIT) || (state == S_OWN_WAIT);
    timeout    = waiting && !((state == S_OPP_WAIT) ? opp_done : own_done)
                 && (wdog == 32'(WDOG_CYCLES - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (in_valid) state_nxt = S_EVAL;
      S_EVAL: begin
        if (rem == 16'd0)   state_nxt = S_IDLE;
        else if (crosses)   state_nxt = S_OPP_WAIT;
        else if (!own_full) state_nxt = S_OWN_WAIT;
        else                state_nxt = S_IDLE;
      end
      S_OPP_WAIT: begin
        if (opp_done)     state_nxt = (rem != 16'd0) ? S_EVAL : S_IDLE;
        else if (timeout) state_nxt = S_IDLE;
      end
      S_OWN_WAIT: if (own_done || timeout) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_val    = CMD_NOP;
    cmd_data   = '0;
    cmd_to_bid = side;
    fire_trade = 1'b0;
    fire_drop  = 1'b0;
    rem_nxt    = rem;
    case (state)
      S_IDLE: if (in_valid) rem_nxt = qty_of(in_order);
      S_EVAL: begin
        if (rem == 16'd0) begin
          fire_drop = 1'b1;
        end else if (crosses) begin
          fire_trade = 1'b1;
          cmd_to_bid = !side;
          if (root_qty > rem) begin
            cmd_val  = CMD_UPDATE;
            cmd_data = mk_order(root_price, root_qty - rem);
            rem_nxt  = '0;
          end else begin
            cmd_val  = CMD_POP;
            cmd_data = opp_root;
            rem_nxt  = rem - root_qty;
          end
        end else if (!own_full) begin
          cmd_val  = CMD_PUSH;
          cmd_data = mk_order(price, rem);
        end else begin
          fire_drop = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      side        <= SIDE_ASK;
      price       <= '0;
      rem         <= '0;
      wdog        <= '0;
      bid_cmd     <= CMD_NOP;
      ask_cmd     <= CMD_NOP;
      bid_data    <= '0;
      ask_data    <= '0;
      trade_valid <= 1'b0;
      trade_price <= '0;
      trade_qty   <= '0;
      trade_side  <= 1'b0;
      drop_valid  <= 1'b0;
      err_timeout <= 1'b0;
      trade_count <= '0;
    end else begin
      rem         <= rem_nxt;
      wdog        <= waiting ? wdog + 32'd1 : '0;
      bid_cmd     <= CMD_NOP;
      ask_cmd     <= CMD_NOP;
      trade_valid <= fire_trade;
      drop_valid  <= fire_drop;
      if (in_valid && in_ready) begin
        side  <= in_side;
        price <= price_of(in_order);
      end
      // data holds between commands; only the target heap sees a one-cycle cmd
      if (cmd_val != CMD_NOP) begin
        if (cmd_to_bid) begin
          bid_cmd  <= cmd_val;
          bid_data <= cmd_data;
        end else begin
          ask_cmd  <= cmd_val;
          ask_data <= cmd_data;
        end
      end
      if (fire_trade) begin
        trade_price <= root_price;
        trade_qty   <= fill_qty;
        trade_side  <= side;
        trade_count <= trade_count + 32'd1;
      end
      if (timeout) err_timeout <= 1'b1;
    end
  end

endmodule
